// File: rtl/tm_byte_coder.sv
// tm_byte_coder: takes one byte per q/q_rdy handshake and sends it as a framed,
// Manchester-coded bit stream on a differential line. A frame is a START sync
// violation, eight data bits (MSB first), one odd-parity bit, and optionally a
// few idle gap bits. cd_busy covers the whole frame. byte_sent pulses once in
// the first IDLE cycle after the frame.
module tm_byte_coder #(
    parameter int HALF_BIT_CLKS = 2,
    parameter int GAP_BITS      = 1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] q,
    input  logic       q_rdy,
    output logic       cd_busy,
    output logic       line_p,
    output logic       line_n,
    output logic       line_oe,
    output logic       byte_sent
);

    // The half-bit tick counter needs at least one bit, even when H=1 and it stays at 0.
    localparam int                TICK_W    = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(HALF_BIT_CLKS - 1);
    localparam logic [3:0]        DATA_LAST = 4'd7;
    localparam logic [3:0]        GAP_LAST  = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        GAP
    } state_t;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              half_q, half_d;
    logic [3:0]        bitCnt_q, bitCnt_d;
    logic [7:0]        shiftReg_q, shiftReg_d;
    logic              parityBit_q, parityBit_d;

    logic              busy_d;
    logic              lineOe_d;
    logic              lineP_d;

    // Frame sequencing: accept a byte in IDLE, then count half-bits and bits
    // to step START -> DATA x8 -> PARITY -> GAP -> IDLE.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        half_d      = half_q;
        bitCnt_d    = bitCnt_q;
        shiftReg_d  = shiftReg_q;
        parityBit_d = parityBit_q;

        if (state_q == IDLE) begin
            if (q_rdy) begin
                state_d     = START;
                tick_d      = '0;
                half_d      = 1'b0;
                bitCnt_d    = '0;
                shiftReg_d  = q;
                parityBit_d = ~^q;
            end
        end else if (tick_q != TICK_LAST) begin
            tick_d = tick_q + TICK_W'(1);
        end else begin
            tick_d = '0;
            if (!half_q) begin
                half_d = 1'b1;
            end else begin
                // The second half of a bit period has ended, so move to the next bit.
                half_d = 1'b0;
                case (state_q)
                    START: begin
                        state_d  = DATA;
                        bitCnt_d = '0;
                    end
                    DATA: begin
                        shiftReg_d = {shiftReg_q[6:0], 1'b0};
                        if (bitCnt_q == DATA_LAST) begin
                            state_d  = PARITY;
                            bitCnt_d = '0;
                        end else begin
                            bitCnt_d = bitCnt_q + 4'd1;
                        end
                    end
                    PARITY: begin
                        bitCnt_d = '0;
                        state_d  = (GAP_BITS == 0) ? IDLE : GAP;
                    end
                    GAP: begin
                        if (bitCnt_q == GAP_LAST) begin
                            state_d  = IDLE;
                            bitCnt_d = '0;
                        end else begin
                            bitCnt_d = bitCnt_q + 4'd1;
                        end
                    end
                    default: begin
                        state_d  = IDLE;
                        bitCnt_d = '0;
                    end
                endcase
            end
        end
    end

    // Line levels for the upcoming cycle. They are computed from the next state,
    // so the registered outputs line up with cd_busy. Manchester coding is the
    // bit XOR the half-bit phase.
    always_comb begin
        busy_d   = 1'b0;
        lineOe_d = 1'b0;
        lineP_d  = 1'b0;
        case (state_d)
            START: begin
                busy_d   = 1'b1;
                lineOe_d = 1'b1;
                lineP_d  = 1'b1;
            end
            DATA: begin
                busy_d   = 1'b1;
                lineOe_d = 1'b1;
                lineP_d  = shiftReg_d[7] ^ half_d;
            end
            PARITY: begin
                busy_d   = 1'b1;
                lineOe_d = 1'b1;
                lineP_d  = parityBit_d ^ half_d;
            end
            GAP: begin
                busy_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, counters and all outputs are registered together.
    // An asynchronous reset stops any frame in progress immediately.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            half_q      <= 1'b0;
            bitCnt_q    <= '0;
            shiftReg_q  <= '0;
            parityBit_q <= 1'b0;
            cd_busy     <= 1'b0;
            line_p      <= 1'b0;
            line_n      <= 1'b0;
            line_oe     <= 1'b0;
            byte_sent   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            half_q      <= half_d;
            bitCnt_q    <= bitCnt_d;
            shiftReg_q  <= shiftReg_d;
            parityBit_q <= parityBit_d;
            cd_busy     <= busy_d;
            line_p      <= lineP_d;
            line_n      <= lineOe_d & ~lineP_d;
            line_oe     <= lineOe_d;
            byte_sent   <= (state_d == IDLE) && (state_q != IDLE);
        end
    end

endmodule
